// File: rtl/countdown_core_if.sv
// ---------------------------------------------------------------------------
// countdown_core_if
// Groups the button levels feeding the countdown timer and the registered
// display/status signals it returns.
//   master : drives the five button levels, observes digits and status
//   slave  : the timer core (receives buttons, drives digits and status)
// Signals:
//   incrementSeconds, incrementMinutes, start, stop, delete  button levels
//   min_tens, min_ones, sec_tens, sec_ones                   BCD digits
//   running, alarm, blink                                    status flags
// ---------------------------------------------------------------------------
interface countdown_core_if;
  logic       incrementSeconds;
  logic       incrementMinutes;
  logic       start;
  logic       stop;
  logic       delete;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       alarm;
  logic       blink;

  modport master (
    output incrementSeconds, incrementMinutes, start, stop, delete,
    input  min_tens, min_ones, sec_tens, sec_ones, running, alarm, blink
  );

  modport slave (
    input  incrementSeconds, incrementMinutes, start, stop, delete,
    output min_tens, min_ones, sec_tens, sec_ones, running, alarm, blink
  );
endinterface

// File: rtl/countdown_core.sv
// ---------------------------------------------------------------------------
// countdown_core
// MM:SS countdown timer with BCD display outputs. Buttons are edge-detected
// (one event per press), time is set in IDLE/PAUSE, counted down once per
// second in RUN, and DONE raises the alarm.
// Parameters:
//   CLK_HZ     clock frequency; prescaler divides it down to the 1 s tick
// Ports:
//   CLK_50MHZ  system clock, rising edge
//   reset      asynchronous active-low reset
//   bus        countdown_core_if.slave (buttons in, digits/status out)
// Build option:
//   COUNTDOWN_BLINK_EN  defined   -> blink flashes at half-second rate in DONE
//                       undefined -> blink is a copy of alarm
// ---------------------------------------------------------------------------
module countdown_core #(
  parameter int CLK_HZ = 50000000
) (
  input  logic             CLK_50MHZ,
  input  logic             reset,
  countdown_core_if.slave  bus
);

  localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mt_q, mo_q, st_q, so_q;
  logic [3:0]    mt_d, mo_d, st_d, so_d;
  logic [PW-1:0] pre_q, pre_d;

  logic [4:0]    smp_q, prv_q;
  logic          armed_q;
  logic [4:0]    btn, ev;
  logic          ev_del, ev_stop, ev_start, ev_mins, ev_secs;
  logic          tick, time_zero, last_sec;

  assign btn = {bus.delete, bus.stop, bus.start,
                bus.incrementMinutes, bus.incrementSeconds};
  assign ev  = smp_q & ~prv_q;
  assign {ev_del, ev_stop, ev_start, ev_mins, ev_secs} = ev;

  // On the first edge after reset the previous-sample register loads the
  // live input too, so a button already held through reset release never
  // looks like a fresh press.
  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      smp_q   <= '0;
      prv_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      smp_q   <= btn;
      prv_q   <= armed_q ? smp_q : btn;
      armed_q <= 1'b1;
    end
  end

  assign tick      = (pre_q == PRE_MAX);
  assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
  assign last_sec  = ({mt_q, mo_q, st_q} == 12'h000) && (so_q == 4'd1);

  // Events are handled strictly by priority; a stop in RUN freezes the
  // prescaler so a coincident tick is dropped rather than counted.
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    pre_d   = pre_q;
    if (ev_del) begin
      state_d = S_IDLE;
      mt_d    = 4'd0;
      mo_d    = 4'd0;
      st_d    = 4'd0;
      so_d    = 4'd0;
      pre_d   = '0;
    end else if (ev_stop) begin
      if (state_q == S_RUN)       state_d = S_PAUSE;
      else if (state_q == S_DONE) state_d = S_IDLE;
    end else if (state_q == S_RUN) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (so_q != 4'd0) begin
          so_d = so_q - 4'd1;
        end else begin
          so_d = 4'd9;
          if (st_q != 4'd0) begin
            st_d = st_q - 4'd1;
          end else begin
            // Borrow from minutes; RUN never holds 00:00 so minutes are nonzero.
            st_d = 4'd5;
            if (mo_q != 4'd0) begin
              mo_d = mo_q - 4'd1;
            end else begin
              mo_d = 4'd9;
              mt_d = mt_q - 4'd1;
            end
          end
        end
        if (last_sec) state_d = S_DONE;
      end
    end else if (ev_start) begin
      if ((state_q == S_IDLE || state_q == S_PAUSE) && !time_zero) begin
        state_d = S_RUN;
        if (state_q == S_IDLE) pre_d = '0;
      end
    end else if (state_q == S_IDLE || state_q == S_PAUSE) begin
      if (ev_secs) begin
        if (so_q == 4'd9) begin
          so_d = 4'd0;
          st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
        end else begin
          so_d = so_q + 4'd1;
        end
      end
      if (ev_mins) begin
        if (mo_q == 4'd9) begin
          mo_d = 4'd0;
          mt_d = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;
        end else begin
          mo_d = mo_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      pre_q   <= pre_d;
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  localparam int            HALF     = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
  localparam int            HW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HALF_MAX = HW'(HALF - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          blink_q, blink_d;

  // Blink starts high on the DONE-entry edge and flips every HALF cycles.
  always_comb begin
    hcnt_d  = '0;
    blink_d = 1'b0;
    if (state_d == S_DONE) begin
      if (state_q != S_DONE) begin
        blink_d = 1'b1;
      end else if (hcnt_q == HALF_MAX) begin
        blink_d = ~blink_q;
      end else begin
        hcnt_d  = hcnt_q + HW'(1);
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      hcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      blink_q <= blink_d;
    end
  end

  assign bus.blink = blink_q;
`else
  assign bus.blink = (state_q == S_DONE);
`endif

  assign bus.min_tens = mt_q;
  assign bus.min_ones = mo_q;
  assign bus.sec_tens = st_q;
  assign bus.sec_ones = so_q;
  assign bus.running  = (state_q == S_RUN);
  assign bus.alarm    = (state_q == S_DONE);

endmodule

// File: tb/tb_countdown_core.sv
module tb_countdown_core;
  localparam int HZ = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  countdown_core_if cif();

  countdown_core #(.CLK_HZ(HZ)) dut (
    .CLK_50MHZ (clk),
    .reset     (reset),
    .bus       (cif)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as plain minutes/seconds integers.
  int       mst = M_IDLE, mmin = 0, msec = 0, mpre = 0, mdone = 0, nedge = 0;
  bit [4:0] h1 = '0, h2 = '0;

  function automatic bit [4:0] raw_btn();
    return {cif.delete, cif.stop, cif.start, cif.incrementMinutes, cif.incrementSeconds};
  endfunction

  always @(posedge clk or negedge reset) begin
    bit [4:0] ev;
    int       total;
    int       prev_st;
    if (!reset) begin
      mst = M_IDLE; mmin = 0; msec = 0; mpre = 0; mdone = 0; nedge = 0;
      h1 = '0; h2 = '0;
    end else begin
      if (nedge < 3) nedge++;
      // A press counts when the level seen one edge ago is high and the one
      // before that low; the two edges after reset release cannot qualify.
      ev = (nedge >= 3) ? (h1 & ~h2) : 5'b0;
      h2 = h1;
      h1 = raw_btn();
      total   = mmin * 60 + msec;
      prev_st = mst;
      if (ev[4]) begin
        mst = M_IDLE; mmin = 0; msec = 0; mpre = 0;
      end else if (ev[3]) begin
        if (mst == M_RUN) mst = M_PAUSE;
        else if (mst == M_DONE) mst = M_IDLE;
      end else if (mst == M_RUN) begin
        if (mpre == HZ - 1) begin
          mpre = 0;
          total = total - 1;
          mmin = total / 60;
          msec = total % 60;
          if (total == 0) mst = M_DONE;
        end else begin
          mpre++;
        end
      end else if (ev[2]) begin
        if ((mst == M_IDLE || mst == M_PAUSE) && total != 0) begin
          if (mst == M_IDLE) mpre = 0;
          mst = M_RUN;
        end
      end else if (mst == M_IDLE || mst == M_PAUSE) begin
        if (ev[0]) msec = (msec + 1) % 60;
        if (ev[1]) mmin = (mmin + 1) % 100;
      end
      if (mst == M_DONE) mdone = (prev_st == M_DONE) ? mdone + 1 : 0;
    end
  end

  function automatic int m_digits();
    return ((mmin / 10) << 12) | ((mmin % 10) << 8) | ((msec / 10) << 4) | (msec % 10);
  endfunction

  function automatic int m_blink();
`ifdef COUNTDOWN_BLINK_EN
    return (mst == M_DONE && ((mdone / (HZ / 2)) % 2) == 0) ? 1 : 0;
`else
    return (mst == M_DONE) ? 1 : 0;
`endif
  endfunction

  function automatic int dig();
    return int'({cif.min_tens, cif.min_ones, cif.sec_tens, cif.sec_ones});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_digits",  dig(), m_digits());
    chk("model_running", int'(cif.running), (mst == M_RUN) ? 1 : 0);
    chk("model_alarm",   int'(cif.alarm),   (mst == M_DONE) ? 1 : 0);
    chk("model_blink",   int'(cif.blink),   m_blink());
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       cif.incrementSeconds = v;
      1:       cif.incrementMinutes = v;
      2:       cif.start            = v;
      3:       cif.stop             = v;
      default: cif.delete           = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk); set_btn(b, 1'b1);
    repeat (2) @(negedge clk);
    set_btn(b, 1'b0);
    @(negedge clk);
  endtask

  // Raises start and returns on the negedge right after the start edge.
  task automatic start_now();
    @(negedge clk); cif.start = 1'b1;
    repeat (2) @(negedge clk);
    cif.start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cif.incrementSeconds = 1'b0; cif.incrementMinutes = 1'b0;
    cif.start = 1'b0; cif.stop = 1'b0; cif.delete = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_digits",  dig(), 0);
    chk("reset_running", int'(cif.running), 0);
    chk("reset_alarm",   int'(cif.alarm), 0);
    chk("reset_blink",   int'(cif.blink), 0);
    reset = 1'b1;

    // Seconds wrap without carry
    repeat (61) press(0);
    chk("sec61", dig(), 'h0001);

    // Holding a button is one press; 100 presses wrap minutes
    @(negedge clk); cif.incrementMinutes = 1'b1;
    repeat (100) @(negedge clk);
    cif.incrementMinutes = 1'b0;
    repeat (2) @(negedge clk);
    chk("min_hold", dig(), 'h0101);
    repeat (99) press(1);
    chk("min_wrap", dig(), 'h0001);
    press(4);
    chk("delete", dig(), 0);

    // Start at 00:00 is ignored
    press(2);
    chk("start_zero_run", int'(cif.running), 0);
    chk("start_zero_dig", dig(), 0);

    // One-minute countdown to DONE
    press(1);
    chk("set_0100", dig(), 'h0100);
    start_now();
    chk("run1_running", int'(cif.running), 1);
    repeat (9) @(negedge clk);
    chk("run1_9cyc", dig(), 'h0100);
    @(negedge clk);
    chk("run1_10cyc", dig(), 'h0059);
    repeat (589) @(negedge clk);
    chk("run1_599", dig(), 'h0001);
    chk("run1_599_run", int'(cif.running), 1);
    @(negedge clk);
    chk("run1_600", dig(), 0);
    chk("run1_alarm", int'(cif.alarm), 1);
    chk("run1_stopped", int'(cif.running), 0);
    chk("blink_entry", int'(cif.blink), 1);
    repeat (5) @(negedge clk);
`ifdef COUNTDOWN_BLINK_EN
    chk("blink_half", int'(cif.blink), 0);
`else
    chk("blink_half", int'(cif.blink), 1);
`endif
    repeat (5) @(negedge clk);
    chk("blink_full", int'(cif.blink), 1);
    press(3);
    chk("done_stop_alarm", int'(cif.alarm), 0);
    chk("done_stop_blink", int'(cif.blink), 0);
    chk("done_stop_dig", dig(), 0);

    // Pause keeps the prescaler phase
    repeat (3) press(0);
    chk("set_0003", dig(), 'h0003);
    start_now();
    repeat (14) @(negedge clk);
    cif.stop = 1'b1;
    repeat (2) @(negedge clk);
    cif.stop = 1'b0;
    chk("pause_running", int'(cif.running), 0);
    chk("pause_dig", dig(), 'h0002);
    repeat (50) @(negedge clk);
    chk("pause_hold", dig(), 'h0002);
    start_now();
    chk("resume_running", int'(cif.running), 1);
    repeat (4) @(negedge clk);
    chk("resume_4", dig(), 'h0002);
    @(negedge clk);
    chk("resume_5", dig(), 'h0001);

    // Delete beats a coincident start while running
    @(negedge clk); cif.delete = 1'b1; cif.start = 1'b1;
    repeat (2) @(negedge clk);
    cif.delete = 1'b0; cif.start = 1'b0;
    chk("del_start_run", int'(cif.running), 0);
    chk("del_start_dig", dig(), 0);

    // Reset mid-countdown with a button held through release
    press(0); press(0);
    start_now();
    repeat (7) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midreset_dig", dig(), 0);
    chk("midreset_run", int'(cif.running), 0);
    cif.incrementSeconds = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_release", dig(), 0);
    cif.incrementSeconds = 1'b0;
    repeat (3) @(negedge clk);
    press(0);
    chk("after_reset_inc", dig(), 'h0001);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0)   cif.incrementSeconds = ~cif.incrementSeconds;
      if ($urandom_range(0, 90) == 0)  cif.incrementMinutes = ~cif.incrementMinutes;
      if ($urandom_range(0, 30) == 0)  cif.start = ~cif.start;
      if ($urandom_range(0, 70) == 0)  cif.stop = ~cif.stop;
      if ($urandom_range(0, 400) == 0) cif.delete = ~cif.delete;
    end
    cif.incrementSeconds = 1'b0; cif.incrementMinutes = 1'b0;
    cif.start = 1'b0; cif.stop = 1'b0; cif.delete = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_core.md
COUNTDOWN_CORE -- requirements
Module: countdown_core

Interface
REQ-001 CLK_HZ, 50000000, input clock frequency in Hz; prescaler divide ratio for the 1 Hz tick.
REQ-002 CLK_50MHZ  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 incrementSeconds  input  1  level from button conditioner; rising edge adds one second.
REQ-005 incrementMinutes  input  1  level; rising edge adds one minute.
REQ-006 start  input  1  level; rising edge starts or resumes the countdown.
REQ-007 stop  input  1  level; rising edge pauses the countdown.
REQ-008 delete  input  1  level; rising edge clears time to 00:00 and returns to IDLE.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD digits for the VGA renderer.
REQ-010 running  output  1  high only in state RUN.
REQ-011 alarm  output  1  high only in state DONE.
REQ-012 blink  output  1  display-flash enable for the VGA renderer (see Configuration).

Function
REQ-013 Each of the five control inputs SHALL be registered once; an event is sampled-high AND previous-sample-low, giving one event per press regardless of hold time.
REQ-014 Outputs SHALL reflect an event on the second rising CLK_50MHZ edge after the input first samples high.
REQ-015 States: IDLE, RUN, PAUSE, DONE; state and digits fully registered.
REQ-016 Event priority in any one cycle: delete > stop > start > increments; lower-priority events in that cycle are discarded.
REQ-017 incrementSeconds in IDLE or PAUSE: seconds 00..59, 59 wraps to 00 with no carry into minutes.
REQ-018 incrementMinutes in IDLE or PAUSE: minutes 00..99, 99 wraps to 00.
REQ-019 Both increment events in one cycle SHALL both apply; increments in RUN or DONE are ignored.
REQ-020 start in IDLE or PAUSE with time != 00:00 -> RUN; with time == 00:00 ignored; ignored in RUN/DONE.
REQ-021 Prescaler counts 0..CLK_HZ-1, width ceil(log2(CLK_HZ)); tick asserted one cycle at CLK_HZ-1; cleared on entry to RUN from IDLE, held (not cleared) in PAUSE, cleared on delete.
REQ-022 Tick in RUN: seconds decrement; at 00 seconds -> 59 and minutes decrement.
REQ-023 Decrement reaching 00:00 SHALL move to DONE in the same edge; alarm high from that edge.
REQ-024 stop in RUN -> PAUSE; a tick coincident with stop SHALL not decrement.
REQ-025 stop in DONE -> IDLE, alarm low, time stays 00:00; stop in IDLE/PAUSE ignored.
REQ-026 delete in any state -> IDLE, digits 0, alarm 0, prescaler 0; overrides a coincident tick.
REQ-027 BCD digits SHALL never hold values outside 0..9 and sec_tens never exceed 5.

Reset
REQ-028 reset low SHALL immediately force state IDLE, all digits 0, running 0, alarm 0, blink 0, prescaler 0, edge-detect registers 0.
REQ-029 Release of reset SHALL take effect on a clock edge; a button held high through release SHALL not generate an event.
REQ-030 Reset asserted mid-countdown SHALL discard time and state with no residual tick.

Configuration
REQ-031 COUNTDOWN_BLINK_EN defined: in DONE, blink toggles every CLK_HZ/2 cycles starting at 1 on DONE entry; blink 0 outside DONE.
REQ-032 COUNTDOWN_BLINK_EN undefined: blink equals alarm; no half-period counter synthesized.

Verification (bench uses CLK_HZ = 10)
REQ-033 Reset, press incrementSeconds 61 times -> digits 00:01 (59 wraps to 00, minutes unchanged).
REQ-034 Set 01:00, start -> running=1; after 10 cycles 00:59; after 600 total cycles 00:00, alarm=1, running=0.
REQ-035 Set 00:03, start, stop after 15 cycles (00:02, prescaler 5), wait 50 cycles, start -> 00:01 exactly 5 cycles after resume.
REQ-036 start at 00:00 -> state stays IDLE, running=0; delete and start same cycle while RUN -> IDLE, 00:00.
REQ-037 Hold incrementMinutes high 100 cycles -> minutes increment by exactly 1; press 100 times from 00 -> 00.
REQ-038 In DONE with COUNTDOWN_BLINK_EN -> blink period 10 cycles; without -> blink constant 1; stop -> alarm=0, blink=0.
